tp_pingpong_buf: RTL and testbench

TP_PINGPONG_BUF -- requirements
Module: tp_pingpong_buf

---
 rtl/tp_pkg.sv | 22 ++
 rtl/tp_bank.sv | 60 ++++++
 rtl/tp_pingpong_buf.sv | 146 ++++++++++++++
 tb/tb_tp_pingpong_buf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// Shared definitions for the transpose ping-pong buffer.
//
// Contents:
//   TP_DEF_N  - default block dimension (rows = columns)
//   TP_DEF_W  - default element width in bits
//   MODE_TP   - block is emitted column by column (transposed)
//   MODE_PASS - block is emitted row by row (unchanged)
//   tp_idx_w  - width of a row/column index for an N x N block
package tp_pkg;

  localparam int unsigned TP_DEF_N = 8;
  localparam int unsigned TP_DEF_W = 12;

  localparam logic MODE_TP   = 1'b0;
  localparam logic MODE_PASS = 1'b1;

  // Index width for a block of dimension n; never below one bit.
  function automatic int unsigned tp_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tp_bank.sv
// Single N x N register bank of W-bit elements.
//
// Rows are written whole through a row write port. The read port is purely
// combinational and returns either a stored row (pass-through) or a column
// gathered across all rows (transpose), selected by i_mode.
//
// Ports:
//   i_clk      - rising-edge clock
//   i_we       - write enable for row i_wr_row
//   i_wr_row   - row being written
//   i_wr_data  - row data, element k at bits [k*W +: W]
//   i_mode     - MODE_TP: read column i_rd_idx; MODE_PASS: read row i_rd_idx
//   i_rd_idx   - row/column index for the read port
//   o_rd_data  - read vector, same packing as i_wr_data
//
// Storage is intentionally not reset: the owner tracks validity with its own
// full flags, so stale contents are never presented.
module tp_bank
  import tp_pkg::*;
#(
  parameter int unsigned N = TP_DEF_N,
  parameter int unsigned W = TP_DEF_W,
  localparam int unsigned IW = tp_idx_w(N)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [IW-1:0]   i_wr_row,
  input  logic [N*W-1:0]  i_wr_data,
  input  logic            i_mode,
  input  logic [IW-1:0]   i_rd_idx,
  output logic [N*W-1:0]  o_rd_data
);

  logic [N*W-1:0] mem_q [N];
  logic [N*W-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (i_we) begin
      mem_d[i_wr_row] = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // Column read picks element i_rd_idx out of every row.
  always_comb begin
    o_rd_data = '0;
    if (i_mode == MODE_PASS) begin
      o_rd_data = mem_q[i_rd_idx];
    end else begin
      for (int k = 0; k < N; k++) begin
        o_rd_data[k*W +: W] = mem_q[k][i_rd_idx*W +: W];
      end
    end
  end

endmodule

// File: rtl/tp_pingpong_buf.sv
// Double-buffered block transposer.
//
// Rows of an N x N block are written into one bank while the other bank is
// read out as N vectors, either transposed (columns) or unchanged (rows).
// The output mode is captured per bank when row 0 of a block is written.
//
// Ports:
//   i_clk      - rising-edge clock
//   i_Reset    - asynchronous, active-high reset
//   i_valid    - input row valid
//   o_ready    - a row can be accepted this cycle
//   i_data     - input row, element k at bits [k*W +: W]
//   i_mode     - 0 = transpose, 1 = pass-through (sampled on row 0)
//   o_valid    - output vector valid
//   i_ready    - downstream accepts the output vector
//   o_data     - output vector, same packing as i_data
//   o_idx      - index of the vector within its block
//   o_last     - final vector of a block
//   o_blk_cnt  - number of fully emitted blocks, wraps at 2^16
module tp_pingpong_buf
  import tp_pkg::*;
#(
  parameter int unsigned N = TP_DEF_N,
  parameter int unsigned W = TP_DEF_W,
  localparam int unsigned IW = tp_idx_w(N)
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [N*W-1:0]  i_data,
  input  logic            i_mode,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N*W-1:0]  o_data,
  output logic [IW-1:0]   o_idx,
  output logic            o_last,
  output logic [15:0]     o_blk_cnt
);

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  // Write side: bank pointer and row counter.
  logic            wr_sel_q, wr_sel_d;
  logic [IW-1:0]   wr_row_q, wr_row_d;
  // Read side: bank pointer and vector index.
  logic            rd_sel_q, rd_sel_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  // Per-bank state: block complete and awaiting readout, latched mode.
  logic [1:0]      full_q, full_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     blk_cnt_q, blk_cnt_d;

  logic            wr_fire;
  logic            rd_fire;
  logic [1:0]      bank_we;
  logic [N*W-1:0]  bank_rd_data [2];

  // Handshake and output view. Outputs depend only on registered state, so
  // there is no combinational path from i_data or i_ready to any output.
  always_comb begin
    o_ready = ~full_q[wr_sel_q];
    o_valid = full_q[rd_sel_q];
    wr_fire = i_valid & o_ready;
    rd_fire = o_valid & i_ready;
    bank_we = '0;
    bank_we[wr_sel_q] = wr_fire;
    o_data  = bank_rd_data[rd_sel_q];
    o_idx   = rd_idx_q;
    o_last  = o_valid & (rd_idx_q == LastIdx);
    o_blk_cnt = blk_cnt_q;
  end

  // Write and read sides update independently. A write can only target an
  // empty bank and a read only a full one, so they never touch the same
  // full flag in one cycle.
  always_comb begin
    wr_sel_d  = wr_sel_q;
    wr_row_d  = wr_row_q;
    rd_sel_d  = rd_sel_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    mode_d    = mode_q;
    blk_cnt_d = blk_cnt_q;

    if (wr_fire) begin
      if (wr_row_q == '0) begin
        mode_d[wr_sel_q] = i_mode;
      end
      if (wr_row_q == LastIdx) begin
        wr_row_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_idx_q == LastIdx) begin
        rd_idx_d         = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        blk_cnt_d        = blk_cnt_q + 16'd1;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_sel_q  <= 1'b0;
      wr_row_q  <= '0;
      rd_sel_q  <= 1'b0;
      rd_idx_q  <= '0;
      full_q    <= '0;
      mode_q    <= {MODE_TP, MODE_TP};
      blk_cnt_q <= '0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      wr_row_q  <= wr_row_d;
      rd_sel_q  <= rd_sel_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tp_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .i_clk     (i_clk),
      .i_we      (bank_we[b]),
      .i_wr_row  (wr_row_q),
      .i_wr_data (i_data),
      .i_mode    (mode_q[b]),
      .i_rd_idx  (rd_idx_q),
      .o_rd_data (bank_rd_data[b])
    );
  end

endmodule

// File: tb/tb_tp_pingpong_buf.sv
// Self-checking bench for tp_pingpong_buf. The reference model keeps a queue
// of complete blocks (rows plus mode) and derives every output from it.
module tb_tp_pingpong_buf;

  localparam int N  = 8;
  localparam int W  = 12;
  localparam int IW = 3;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic            o_ready;
  logic [N*W-1:0]  i_data;
  logic            i_mode;
  logic            o_valid;
  logic            i_ready;
  logic [N*W-1:0]  o_data;
  logic [IW-1:0]   o_idx;
  logic            o_last;
  logic [15:0]     o_blk_cnt;

  tp_pingpong_buf #(
    .N (N),
    .W (W)
  ) dut (
    .i_clk     (clk),
    .i_Reset   (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_mode    (i_mode),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_idx     (o_idx),
    .o_last    (o_last),
    .o_blk_cnt (o_blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                  mode;
    logic [N-1:0][N*W-1:0] rows;
  } blk_t;

  blk_t           done_q [$];
  blk_t           part;
  int             part_cnt;
  int             rd_idx_m;
  logic [15:0]    blk_cnt_m;
  int             errors;
  int             checks;
  logic [N*W-1:0] obs_data;
  logic           obs_ready;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vector j of a block, straight from the definition of the two modes.
  function automatic logic [N*W-1:0] exp_vec(input blk_t b, input int j);
    logic [N*W-1:0] v;
    logic [N*W-1:0] row;
    v = '0;
    if (b.mode) begin
      v = b.rows[j];
    end else begin
      for (int k = 0; k < N; k++) begin
        row = b.rows[k];
        v[k*W +: W] = row[j*W +: W];
      end
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] seq_row(input int r);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(N * r + k);
    return v;
  endfunction

  // Expected vector j of the counting block in the given mode.
  function automatic logic [N*W-1:0] seq_vec(input int j, input logic pass);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = pass ? W'(N * j + k) : W'(N * k + j);
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_row();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    done_q.delete();
    part_cnt  = 0;
    rd_idx_m  = 0;
    blk_cnt_m = '0;
  endtask

  // One clock cycle: apply inputs, check outputs, then advance the model.
  task automatic cycle(input logic v, input logic [N*W-1:0] d, input logic m, input logic r);
    logic exp_ready, exp_valid, wf, rf;
    blk_t head;
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    i_mode  = m;
    i_ready = r;
    #1;
    exp_ready = (done_q.size() < 2);
    exp_valid = (done_q.size() > 0);
    obs_data  = o_data;
    obs_ready = o_ready;
    check_eq("o_ready", o_ready, exp_ready);
    check_eq("o_valid", o_valid, exp_valid);
    check_eq("o_blk_cnt", o_blk_cnt, blk_cnt_m);
    if (exp_valid) begin
      head = done_q[0];
      check_eq("o_data", o_data, exp_vec(head, rd_idx_m));
      check_eq("o_idx", o_idx, rd_idx_m);
      check_eq("o_last", o_last, rd_idx_m == N - 1);
    end
    wf = v && exp_ready;
    rf = exp_valid && r;
    @(posedge clk);
    if (rf) begin
      rd_idx_m++;
      if (rd_idx_m == N) begin
        void'(done_q.pop_front());
        rd_idx_m = 0;
        blk_cnt_m++;
      end
    end
    if (wf) begin
      if (part_cnt == 0) part.mode = m;
      part.rows[part_cnt] = d;
      part_cnt++;
      if (part_cnt == N) begin
        done_q.push_back(part);
        part_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    rst     = 1'b1;
    #1;
    check_eq("rst_o_valid", o_valid, 1'b0);
    check_eq("rst_o_ready", o_ready, 1'b1);
    check_eq("rst_o_last", o_last, 1'b0);
    check_eq("rst_o_idx", o_idx, 0);
    check_eq("rst_o_blk_cnt", o_blk_cnt, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic all_ready;

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_mode   = 1'b0;
    i_ready  = 1'b0;
    part     = '0;
    model_clear();
    #2 rst = 1'b1;

    do_reset();

    // Transpose of the counting block.
    for (int r = 0; r < N; r++) cycle(1'b1, seq_row(r), 1'b0, 1'b0);
    for (int j = 0; j < N; j++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_eq("tp_vec", obs_data, seq_vec(j, 1'b0));
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("tp_blk_cnt", o_blk_cnt, 16'd1);

    // Pass-through of the same rows.
    do_reset();
    for (int r = 0; r < N; r++) cycle(1'b1, seq_row(r), 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_eq("pass_vec", obs_data, seq_vec(j, 1'b1));
    end

    // Three blocks streamed with both sides always willing.
    do_reset();
    all_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      cycle(1'b1, rand_row(), 1'($urandom_range(0, 1)), 1'b1);
      all_ready &= obs_ready;
    end
    for (int i = 0; i < N + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("stream_ready", all_ready, 1'b1);
    check_eq("stream_blk_cnt", o_blk_cnt, 16'd3);

    // Downstream stall while a second block fills.
    do_reset();
    for (int r = 0; r < N; r++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
    check_eq("stall_ready_low", o_ready, 1'b0);
    for (int i = 0; i < 2 * N + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("stall_blk_cnt", o_blk_cnt, 16'd2);

    // Reset in the middle of a block, then a clean block.
    do_reset();
    for (int r = 0; r < 5; r++) cycle(1'b1, seq_row(r), 1'b0, 1'b1);
    do_reset();
    for (int r = 0; r < N; r++) cycle(1'b1, seq_row(r), 1'b0, 1'b1);
    for (int i = 0; i < N + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("post_rst_blk_cnt", o_blk_cnt, 16'd1);

    // Mode changes mid-block only affect the following block.
    do_reset();
    for (int r = 0; r < N; r++) cycle(1'b1, seq_row(r), (r >= 3) ? 1'b1 : 1'b0, 1'b0);
    for (int r = 0; r < N; r++) cycle(1'b1, seq_row(r), 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_eq("mode_blk0", obs_data, seq_vec(j, 1'b0));
    end
    for (int j = 0; j < N; j++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_eq("mode_blk1", obs_data, seq_vec(j, 1'b1));
    end

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), rand_row(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
